// File: rtl/fp_accum_seq.sv
// Accumulation sequencer for a single-precision adder stage: feeds the running
// sum and next operand to the adder, times its latency, and emits the final sum.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | waiting for start; samples len
// S_WAIT_IN  | in_ready high, waiting for the next operand
// S_ISSUE    | one-cycle add_enable pulse, latency counter loaded
// S_WAIT_ADD | counting out adder latency, then capturing result when done
// S_DONE     | sum_valid pulse, sum holds the final accumulation
module fp_accum_seq #(
    parameter int COUNT_W = 8,
    parameter int ADD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COUNT_W-1:0] len,
    input  logic               in_valid,
    input  logic [31:0]        in_data,
    output logic               in_ready,
    output logic [31:0]        add_dataa,
    output logic [31:0]        add_datab,
    output logic               add_enable,
    input  logic               add_done,
    input  logic [31:0]        add_result,
    output logic               busy,
    output logic               sum_valid,
    output logic [31:0]        sum
);

    localparam int LAT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(ADD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IN,
        S_ISSUE,
        S_WAIT_ADD,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        acc_q, acc_d;
    logic [31:0]        opnd_q, opnd_d;
    logic [31:0]        sum_q, sum_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        sum_d       = sum_q;
        remaining_d = remaining_q;
        lat_cnt_d   = lat_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d       = 32'h0000_0000;
                    remaining_d = len;
                    lat_cnt_d   = '0;
                    if (len == '0) begin
                        sum_d   = 32'h0000_0000;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT_IN;
                    end
                end
            end
            S_WAIT_IN: begin
                if (in_valid) begin
                    opnd_d  = in_data;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                lat_cnt_d = LAT_INIT;
                state_d   = S_WAIT_ADD;
            end
            S_WAIT_ADD: begin
                if (lat_cnt_q != '0) begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end else if (add_done) begin
                    acc_d       = add_result;
                    remaining_d = remaining_q - COUNT_W'(1);
                    // sum is loaded on entry to DONE so it is already final during the pulse
                    if (remaining_q == COUNT_W'(1)) begin
                        sum_d   = add_result;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT_IN;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            opnd_q      <= '0;
            sum_q       <= '0;
            remaining_q <= '0;
            lat_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            opnd_q      <= opnd_d;
            sum_q       <= sum_d;
            remaining_q <= remaining_d;
            lat_cnt_q   <= lat_cnt_d;
        end
    end

    assign in_ready   = (state_q == S_WAIT_IN);
    assign add_enable = (state_q == S_ISSUE);
    assign busy       = (state_q != S_IDLE);
    assign sum_valid  = (state_q == S_DONE);
    assign add_dataa  = acc_q;
    assign add_datab  = opnd_q;
    assign sum        = sum_q;

endmodule

// File: tb/tb_fp_accum_seq.sv
// Bench for fp_accum_seq: two instances (adder latency 1 and 3) driven against
// behavioural float adders; expected sums come from integer arithmetic.
module tb_fp_accum_seq;

    localparam int CW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic          start, in_valid, in_ready, add_enable, busy, sum_valid;
    logic          add_done = 1'b0;
    logic [CW-1:0] len;
    logic [31:0]   in_data, add_dataa, add_datab, sum;
    logic [31:0]   add_result = 32'h0;

    logic          start3, in_valid3, in_ready3, add_enable3, busy3, sum_valid3;
    logic          add_done3 = 1'b0;
    logic [CW-1:0] len3;
    logic [31:0]   in_data3, add_dataa3, add_datab3, sum3;
    logic [31:0]   add_result3 = 32'h0;

    fp_accum_seq #(.COUNT_W(CW), .ADD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .add_dataa(add_dataa), .add_datab(add_datab), .add_enable(add_enable),
        .add_done(add_done), .add_result(add_result),
        .busy(busy), .sum_valid(sum_valid), .sum(sum)
    );

    fp_accum_seq #(.COUNT_W(CW), .ADD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .len(len3),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .add_dataa(add_dataa3), .add_datab(add_datab3), .add_enable(add_enable3),
        .add_done(add_done3), .add_result(add_result3),
        .busy(busy3), .sum_valid(sum_valid3), .sum(sum3)
    );

    function automatic real f2r(input logic [31:0] f);
        real m;
        int  e;
        e = int'(f[30:23]);
        m = real'(f[22:0]) / 8388608.0;
        if (e == 0) m = m * (2.0 ** (-126));
        else        m = (1.0 + m) * (2.0 ** (e - 127));
        return f[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real x);
        real         a;
        int          e;
        logic [31:0] m;
        logic        s;
        if (x == 0.0) return 32'h0;
        s = (x < 0.0);
        a = s ? -x : x;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        m = 32'($rtoi((a - 1.0) * 8388608.0 + 0.5));
        if (m[23]) begin m = 32'h0; e++; end
        return {s, 8'(e + 127), m[22:0]};
    endfunction

    // latency-1 adder with sticky done
    always @(posedge clk) begin
        if (add_enable) begin
            add_result <= r2f(f2r(add_dataa) + f2r(add_datab));
            add_done   <= 1'b1;
        end
    end

    // latency-3 adder: result appears three cycles after enable is sampled
    int          pend3 = 0;
    logic [31:0] pv3 = 32'h0;
    always @(posedge clk) begin
        if (add_enable3) begin
            pend3 <= 2;
            pv3   <= r2f(f2r(add_dataa3) + f2r(add_datab3));
        end else if (pend3 != 0) begin
            if (pend3 == 1) begin
                add_result3 <= pv3;
                add_done3   <= 1'b1;
            end
            pend3 <= pend3 - 1;
        end
    end

    int en_cnt = 0, sv_cnt = 0;
    always @(posedge clk) begin
        if (add_enable) en_cnt <= en_cnt + 1;
        if (sum_valid)  sv_cnt <= sv_cnt + 1;
    end

    int n_checks = 0, n_pass = 0;
    int vals[16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input string tag, input int n, input int gap, input bit poke);
        int          cyc, guard, e0, s0, tot;
        logic [31:0] exp_sum;
        tot = 0;
        for (int i = 0; i < n; i++) tot += vals[i];
        exp_sum = r2f(real'(tot));
        e0 = en_cnt;
        s0 = sv_cnt;
        start = 1'b1; len = CW'(n);
        step(); start = 1'b0; cyc = 1;
        for (int k = 0; k < n; k++) begin
            guard = 0;
            while (!in_ready && guard < 20) begin step(); cyc++; guard++; end
            check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
            for (int g = 0; g < gap; g++) begin
                step(); cyc++;
                check({tag, "_gap_ready"}, 32'(in_ready), 32'd1);
            end
            in_valid = 1'b1; in_data = r2f(real'(vals[k]));
            step(); cyc++; in_valid = 1'b0;
            if (poke && k == 0) begin
                start = 1'b1; len = CW'(7);
                step(); cyc++; start = 1'b0;
            end
        end
        guard = 0;
        while (!sum_valid && guard < 40) begin step(); cyc++; guard++; end
        check({tag, "_sum_valid"}, 32'(sum_valid), 32'd1);
        check({tag, "_sum"}, sum, exp_sum);
        check({tag, "_enables"}, 32'(en_cnt - e0), 32'(n));
        if (gap == 0 && !poke) check({tag, "_cycle"}, 32'(cyc), 32'(1 + 3 * n));
        step();
        check({tag, "_pulse_end"}, 32'(sum_valid), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_pulses"}, 32'(sv_cnt - s0), 32'd1);
        check({tag, "_sum_hold"}, sum, exp_sum);
    endtask

    initial begin
        int cyc, guard, k, s0;
        rst_n = 1'b1;
        start = 0; len = '0; in_valid = 0; in_data = '0;
        start3 = 0; len3 = '0; in_valid3 = 0; in_data3 = '0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_enable", 32'(add_enable), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum_valid", 32'(sum_valid), 32'd0);
        check("rst_sum", sum, 32'h0);
        check("rst_dataa", add_dataa, 32'h0);
        check("rst_datab", add_datab, 32'h0);
        check("rst_busy3", 32'(busy3), 32'd0);
        #10 rst_n = 1'b1;
        step();

        vals[0] = 1; vals[1] = 2; vals[2] = 3;
        run_job("basic", 3, 0, 1'b0);
        check("basic_const", sum, 32'h40C0_0000);

        run_job("empty", 0, 0, 1'b0);
        check("empty_const", sum, 32'h0);

        vals[0] = 5; vals[1] = -2;
        run_job("bkpr", 2, 5, 1'b0);
        check("bkpr_const", sum, 32'h4040_0000);

        vals[0] = 4; vals[1] = 7; vals[2] = -1;
        run_job("ign_start", 3, 0, 1'b1);

        // abort mid-WAIT_ADD of a two-operand job
        start = 1'b1; len = CW'(2);
        step(); start = 1'b0;
        in_valid = 1'b1; in_data = r2f(3.0);
        step(); in_valid = 1'b0;
        check("abort_issue_en", 32'(add_enable), 32'd1);
        check("abort_issue_b", add_datab, 32'h4040_0000);
        step(); step();
        check("abort_wait_in", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = r2f(9.0);
        step(); in_valid = 1'b0;
        step();
        check("abort_busy", 32'(busy), 32'd1);
        check("abort_acc", add_dataa, 32'h4040_0000);
        s0 = sv_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_enable", 32'(add_enable), 32'd0);
        check("abort_busy_rst", 32'(busy), 32'd0);
        check("abort_sum_valid", 32'(sum_valid), 32'd0);
        check("abort_sum", sum, 32'h0);
        check("abort_dataa", add_dataa, 32'h0);
        check("abort_datab", add_datab, 32'h0);
        #2 rst_n = 1'b1;
        step();
        check("abort_busy_after", 32'(busy), 32'd0);
        step(); step(); step();
        check("abort_no_pulse", 32'(sv_cnt - s0), 32'd0);

        for (int j = 0; j < 6; j++) begin
            int n, gap;
            n   = int'($urandom_range(6, 1));
            gap = int'($urandom_range(2, 0));
            for (int i = 0; i < n; i++) vals[i] = int'($urandom_range(100, 0)) - 50;
            run_job($sformatf("rand%0d", j), n, gap, 1'b0);
        end

        // latency-3 instance, first job: done is not yet sticky
        start3 = 1'b1; len3 = CW'(1);
        step(); start3 = 1'b0;
        in_valid3 = 1'b1; in_data3 = 32'h3FC0_0000;
        step(); in_valid3 = 1'b0;
        check("lat3_issue", 32'(add_enable3), 32'd1);
        check("lat3_datab", add_datab3, 32'h3FC0_0000);
        for (int c = 0; c < 3; c++) begin
            step();
            check("lat3_acc_hold", add_dataa3, 32'h0);
            check("lat3_no_valid", 32'(sum_valid3), 32'd0);
        end
        step();
        check("lat3_sum_valid", 32'(sum_valid3), 32'd1);
        check("lat3_sum", sum3, 32'h3FC0_0000);
        check("lat3_acc", add_dataa3, 32'h3FC0_0000);

        // second job: stale sticky done must not cause early capture
        step();
        start3 = 1'b1; len3 = CW'(2);
        step(); start3 = 1'b0;
        cyc = 1; k = 0; guard = 0;
        while (!sum_valid3 && guard < 60) begin
            if (in_ready3 && k < 2) begin
                in_valid3 = 1'b1;
                in_data3  = (k == 0) ? 32'h3F80_0000 : 32'h4000_0000;
                k++;
            end
            step(); in_valid3 = 1'b0; cyc++; guard++;
        end
        check("lat3_job2_valid", 32'(sum_valid3), 32'd1);
        check("lat3_job2_cycle", 32'(cyc), 32'd11);
        check("lat3_job2_sum", sum3, 32'h4040_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_accum_seq.md
# fp_accum_seq

Sequencing controller that sums a stream of IEEE-754 single-precision operands using the existing single-cycle floating-point adder stage. It sits directly upstream of that adder: it accepts operands over a valid/ready stream, presents the running sum and the next operand on the adder's `dataa`/`datab`, and pulses the adder's `enable`. It waits out the adder latency, captures `result`, and emits the final sum with a one-cycle valid pulse. The adder's `done` is sticky (it never clears), so completion is judged by a fixed latency count, with `done` used only as a qualifier.

## Interface
Parameters:
- `COUNT_W`, default 8: width of the operand-count field.
- `ADD_LAT`, default 1: cycles from the adder sampling `enable` to `result` being valid. Legal range is ≥1.

Ports:
- `clk`  in  1  Single clock; all state changes on the rising edge.
- `rst_n`  in  1  Reset, asynchronous and active-low.
- `start`  in  1  Begin an accumulation job; sampled in IDLE only.
- `len`  in  COUNT_W  Number of operands in the job; sampled with `start`.
- `in_valid`  in  1  Operand available.
- `in_data`  in  32  Operand (IEEE-754 single).
- `in_ready`  out  1  Controller can accept an operand.
- `add_dataa`  out  32  To adder `dataa`: the running sum.
- `add_datab`  out  32  To adder `datab`: the current operand.
- `add_enable`  out  1  To adder `enable`.
- `add_done`  in  1  From adder `done` (sticky).
- `add_result`  in  32  From adder `result`.
- `busy`  out  1  High whenever the state is not IDLE.
- `sum_valid`  out  1  One-cycle pulse marking `sum` as final.
- `sum`  out  32  Accumulated result; holds its value until the next job completes.

## Operation
States: IDLE, WAIT_IN, ISSUE, WAIT_ADD, DONE.

IDLE
- On `start`: the accumulator register `acc` is set to 0x00000000, `remaining` is set to `len`, and `lat_cnt` is cleared.
- If `len`==0, go to DONE; otherwise go to WAIT_IN.
- `start` outside IDLE is ignored.

WAIT_IN
- `in_ready`=1.
- On `in_valid && in_ready`: the operand register `opnd` is set to `in_data`, then go to ISSUE.
- Otherwise stay in WAIT_IN. There is no timeout.

ISSUE
- `add_enable`=1 for exactly this one cycle.
- `lat_cnt` is set to ADD_LAT-1, then go to WAIT_ADD.

WAIT_ADD
- `add_enable`=0.
- If `lat_cnt`≠0, decrement it.
- If `lat_cnt`==0 and `add_done`=1:
  - `acc` is set to `add_result` and `remaining` is decremented.
  - Go to DONE if the new `remaining`==0, else go to WAIT_IN.
- If `lat_cnt`==0 and `add_done`=0, hold in WAIT_ADD until `add_done`=1.

DONE
- `sum` is set to `acc` and `sum_valid`=1 for this one cycle.
- Go to IDLE.

General rules:
- `add_dataa`=`acc` and `add_datab`=`opnd` at all times. Both are registers, so they are stable from ISSUE through capture.
- The controller does no arithmetic on the float fields. Zero handling, sign and normalization belong to the adder.
- `in_ready`, `add_enable`, `busy` and `sum_valid` are decoded from the registered state, with no combinational path from inputs.
- `remaining` is COUNT_W bits wide. The maximum job is 2^COUNT_W−1 operands, and no wrap is possible because the decrement happens only when `remaining`≥1.

## Timing
Reset values (asynchronous assert, synchronous deassert assumed upstream):
- state=IDLE.
- `in_ready`=0, `add_enable`=0, `busy`=0, `sum_valid`=0.
- `sum`=0, `acc`=0, `opnd`=0, so `add_dataa`=`add_datab`=0.

Latency:
- Per operand: 2+ADD_LAT cycles from the accept cycle to the next `in_ready`, with ADD_LAT=1 giving 3.
- Job: `start` in cycle 0 puts WAIT_IN in cycle 1. With zero-wait input, `sum_valid` is asserted in cycle 1+N·(2+ADD_LAT).
- `len`=0: `sum_valid` is asserted in cycle 1 with `sum`=0.
- Back-to-back jobs: `start` is accepted in the IDLE cycle that follows DONE.

Reset mid-job:
- All state returns to IDLE at once, and `add_enable` drops asynchronously.
- No `sum_valid` is produced for the aborted job.
- A partially consumed operand is lost; the upstream stage must restart the job.

## Test plan
- Reset check: assert `rst_n`=0 mid-WAIT_ADD → all outputs are at their reset values in the same cycle, and `busy`=0 after release.
- Basic sum: `len`=3, operands 0x3F800000, 0x40000000, 0x40400000 (1.0, 2.0, 3.0) with zero-wait valid → `sum_valid` in cycle 10 with `sum`=0x40C00000 (6.0), and exactly 3 `add_enable` pulses.
- Empty job: `len`=0 → `sum_valid` in cycle 1 with `sum`=0x00000000, and `add_enable` never asserted.
- Backpressure on input: `len`=2 with 5 idle cycles before each `in_valid`, operands 0x40A00000 and 0xC0000000 (5.0, −2.0) → `sum`=0x40400000 (3.0), and `in_ready` stays high throughout each gap.
- Ignored start: pulse `start` with `len`=7 while `busy`=1 → the current job's count is unchanged and there is no extra `sum_valid`.
- Latency parameter: ADD_LAT=3 with the adder model delaying `done` by 3 cycles, single operand 0x3FC00000 → `sum`=0x3FC00000, the capture happens 3 cycles after ISSUE, and `acc` is unchanged before then.
